// File: rtl/ariane_pkg.sv
// Core-wide types used by issue, writeback and commit.
// Contents:
//   TRANS_ID_BITS      - width of a reorder-queue slot index
//   exception_t        - exception record carried with an instruction
//   scoreboard_entry_t - per-instruction payload held in the commit queue
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0]   pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [riscv::XLEN-1:0]   result;
        logic                     valid;     // result has been written back
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/riscv_pkg.sv
// Minimal ISA-level constants shared across the core.
// Only the machine word width is needed by the reorder/commit logic.
package riscv;

    localparam int unsigned XLEN = 64;

endpackage

// File: rtl/rob_commit_queue.sv
// In-order reorder/commit queue.
// Instructions are allocated at the tail in program order, results arrive out of order
// on the writeback ports, and the oldest NR_COMMIT_PORTS entries are presented to the
// commit stage, which retires a contiguous prefix of them each cycle.
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   flush_i                - discard every entry
//   decoded_instr_i/_valid - allocation request; decoded_instr_ack_o accepts it
//   issue_trans_id_o       - slot index handed to the accepted instruction
//   trans_id_i, wbdata_i,
//   ex_i, wt_valid_i       - writeback ports (slot, result, exception, valid)
//   commit_instr_o         - head entries, port 0 oldest; .valid = committable
//   commit_ack_i           - retire a prefix of the presented entries
//   full_o                 - every slot occupied
module rob_commit_queue
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           flush_i,
    input  scoreboard_entry_t                              decoded_instr_i,
    input  logic                                           decoded_instr_valid_i,
    output logic                                           decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                       issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]      trans_id_i,
    input  logic [NR_WB_PORTS-1:0][riscv::XLEN-1:0]        wbdata_i,
    input  exception_t [NR_WB_PORTS-1:0]                   ex_i,
    input  logic [NR_WB_PORTS-1:0]                         wt_valid_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]        commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                     commit_ack_i,
    output logic                                           full_o
);

    localparam int unsigned CntW = TRANS_ID_BITS + 1;

    typedef logic [TRANS_ID_BITS-1:0] idx_t;
    typedef logic [CntW-1:0]          cnt_t;

    // Pointer arithmetic relies on natural wrap of the slot index.
    if (NR_ENTRIES != (1 << TRANS_ID_BITS)) begin : g_bad_depth
        $error("NR_ENTRIES must equal 2**TRANS_ID_BITS");
    end

    scoreboard_entry_t       mem_q [NR_ENTRIES];
    scoreboard_entry_t       mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]   occupied_q, occupied_d;
    idx_t                    head_q, head_d;
    idx_t                    tail_q, tail_d;
    cnt_t                    count_q, count_d;

    logic                    accept;
    cnt_t                    num_retire;

    // Status is derived from registered count only; a same-cycle retire does not
    // free a slot for a same-cycle allocation.
    assign full_o              = (count_q == cnt_t'(NR_ENTRIES));
    assign accept              = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign decoded_instr_ack_o = accept;
    assign issue_trans_id_o    = tail_q;

    always_comb begin
        num_retire = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            num_retire = num_retire + cnt_t'(commit_ack_i[i]);
        end
    end

    // Head window comes straight from state: a writeback becomes visible one cycle later.
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            commit_instr_o[i]       = mem_q[head_q + idx_t'(i)];
            commit_instr_o[i].valid = mem_q[head_q + idx_t'(i)].valid
                                      & occupied_q[head_q + idx_t'(i)];
        end
    end

    always_comb begin
        mem_d      = mem_q;
        occupied_d = occupied_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                occupied_d[e]  = 1'b0;
                mem_d[e].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) begin
                mem_d[tail_q]       = decoded_instr_i;
                mem_d[tail_q].valid = 1'b0;
                occupied_d[tail_q]  = 1'b1;
            end

            // Ascending order lets the highest-numbered port win a slot collision.
            // Occupancy is checked against start-of-cycle state, so writebacks to
            // free slots are dropped.
            for (int w = 0; w < NR_WB_PORTS; w++) begin
                if (wt_valid_i[w] && occupied_q[trans_id_i[w]]) begin
                    mem_d[trans_id_i[w]].valid  = 1'b1;
                    mem_d[trans_id_i[w]].result = wbdata_i[w];
                    if (ex_i[w].valid) begin
                        mem_d[trans_id_i[w]].ex = ex_i[w];
                    end
                end
            end

            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (cnt_t'(i) < num_retire) begin
                    occupied_d[head_q + idx_t'(i)]  = 1'b0;
                    mem_d[head_q + idx_t'(i)].valid = 1'b0;
                end
            end

            head_d  = head_q + idx_t'(num_retire);
            tail_d  = tail_q + idx_t'(accept);
            count_d = count_q + cnt_t'(accept) - num_retire;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                mem_q[e] <= '0;
            end
            occupied_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                mem_q[e] <= mem_d[e];
            end
            occupied_q <= occupied_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Commit must retire a contiguous prefix of committable entries.
    for (genvar gi = 1; gi < NR_COMMIT_PORTS; gi++) begin : g_ack_order
        assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
            commit_ack_i[gi] |-> (commit_ack_i[gi-1] && commit_instr_o[gi].valid));
    end

endmodule

// File: tb/tb_rob_commit_queue.sv
module tb_rob_commit_queue;
    import ariane_pkg::*;

    logic                               clk_i = 1'b0;
    logic                               rst_ni;
    logic                               flush_i;
    scoreboard_entry_t                  decoded_instr_i;
    logic                               decoded_instr_valid_i;
    logic                               decoded_instr_ack_o;
    logic [TRANS_ID_BITS-1:0]           issue_trans_id_o;
    logic [3:0][TRANS_ID_BITS-1:0]      trans_id_i;
    logic [3:0][riscv::XLEN-1:0]        wbdata_i;
    exception_t [3:0]                   ex_i;
    logic [3:0]                         wt_valid_i;
    scoreboard_entry_t [1:0]            commit_instr_o;
    logic [1:0]                         commit_ack_i;
    logic                               full_o;

    rob_commit_queue #(
        .NR_ENTRIES      (8),
        .NR_COMMIT_PORTS (2),
        .NR_WB_PORTS     (4)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .decoded_instr_i       (decoded_instr_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .issue_trans_id_o      (issue_trans_id_o),
        .trans_id_i            (trans_id_i),
        .wbdata_i              (wbdata_i),
        .ex_i                  (ex_i),
        .wt_valid_i            (wt_valid_i),
        .commit_instr_o        (commit_instr_o),
        .commit_ack_i          (commit_ack_i),
        .full_o                (full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] result;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] tb_tail  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb_set(input int port, input logic [2:0] slot, input logic [63:0] data,
                          input bit exv, input logic [63:0] cause);
        wt_valid_i[port]     = 1'b1;
        trans_id_i[port]     = slot;
        wbdata_i[port]       = data;
        ex_i[port]           = '0;
        ex_i[port].valid     = exv;
        ex_i[port].cause     = cause;
    endtask

    task automatic wb_clear();
        wt_valid_i = '0;
        ex_i       = '0;
    endtask

    // Allocate one instruction; its eventual result is queued for commit-time comparison.
    task automatic issue(input logic [63:0] pc, input logic [63:0] res);
        exp_t e;
        decoded_instr_valid_i = 1'b1;
        decoded_instr_i       = '0;
        decoded_instr_i.pc    = pc;
        decoded_instr_i.op    = 8'h13;
        #1;
        check("issue_ack", 64'(decoded_instr_ack_o), 64'd1);
        check("issue_trans_id", 64'(issue_trans_id_o), 64'(tb_tail));
        e.pc = pc;
        e.result = res;
        exp_q.push_back(e);
        tick();
        decoded_instr_valid_i = 1'b0;
        tb_tail = tb_tail + 3'd1;
    endtask

    // Retire n head entries, comparing each against the scoreboard.
    task automatic retire(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check("retire_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("retire_valid", 64'(commit_instr_o[i].valid), 64'd1);
                check("retire_pc", commit_instr_o[i].pc, e.pc);
                check("retire_result", commit_instr_o[i].result, e.result);
            end
            commit_ack_i[i] = 1'b1;
        end
        tick();
        commit_ack_i = '0;
    endtask

    initial begin
        rst_ni                = 1'b0;
        flush_i               = 1'b0;
        decoded_instr_i       = '0;
        decoded_instr_valid_i = 1'b0;
        trans_id_i            = '0;
        wbdata_i              = '0;
        ex_i                  = '0;
        wt_valid_i            = '0;
        commit_ack_i          = '0;

        // Reset state
        #3;
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ack", 64'(decoded_instr_ack_o), 64'd0);
        check("rst_c0_valid", 64'(commit_instr_o[0].valid), 64'd0);
        check("rst_c1_valid", 64'(commit_instr_o[1].valid), 64'd0);
        check("rst_trans_id", 64'(issue_trans_id_o), 64'd0);
        #4 rst_ni = 1'b1;
        tick();

        // Three issues, parallel writeback, no bypass, two-wide retire
        issue(64'h100, 64'h11);
        issue(64'h104, 64'h22);
        issue(64'h108, 64'h33);
        wb_set(0, 3'd0, 64'h11, 1'b0, '0);
        wb_set(1, 3'd1, 64'h22, 1'b0, '0);
        wb_set(2, 3'd2, 64'h33, 1'b0, '0);
        #1;
        check("no_bypass_c0", 64'(commit_instr_o[0].valid), 64'd0);
        tick();
        wb_clear();
        check("wb_c0_result", commit_instr_o[0].result, 64'h11);
        check("wb_c1_result", commit_instr_o[1].result, 64'h22);
        retire(2);
        check("after_retire_c0", commit_instr_o[0].result, 64'h33);
        retire(1);

        // Out-of-order writeback: younger entry written first
        issue(64'h200, 64'hB0);
        issue(64'h204, 64'hB1);
        wb_set(0, 3'd4, 64'hB1, 1'b0, '0);
        tick();
        wb_clear();
        check("ooo_c0_valid", 64'(commit_instr_o[0].valid), 64'd0);
        check("ooo_c1_valid", 64'(commit_instr_o[1].valid), 64'd1);
        wb_set(2, 3'd3, 64'hB0, 1'b0, '0);
        tick();
        wb_clear();
        retire(2);

        // Exception sticks across a later non-exception writeback
        issue(64'h300, 64'h66);
        wb_set(1, 3'd5, 64'h55, 1'b1, 64'd2);
        tick();
        wb_clear();
        check("ex_valid", 64'(commit_instr_o[0].ex.valid), 64'd1);
        check("ex_cause", commit_instr_o[0].ex.cause, 64'd2);
        wb_set(3, 3'd5, 64'h66, 1'b0, '0);
        tick();
        wb_clear();
        check("ex_kept_valid", 64'(commit_instr_o[0].ex.valid), 64'd1);
        check("ex_kept_cause", commit_instr_o[0].ex.cause, 64'd2);
        retire(1);

        // Pointer wrap: head=6, trans ids 6,7,0,1
        for (int k = 0; k < 4; k++) issue(64'h400 + 64'(4 * k), 64'hA0 + 64'(k));
        for (int k = 0; k < 4; k++) wb_set(k, 3'(6 + k), 64'hA0 + 64'(k), 1'b0, '0);
        tick();
        wb_clear();
        retire(2);
        retire(2);
        check("wrap_c0_stale", 64'(commit_instr_o[0].valid), 64'd0);
        check("wrap_c1_stale", 64'(commit_instr_o[1].valid), 64'd0);
        check("wrap_tail", 64'(issue_trans_id_o), 64'd2);

        // Fill to full; a same-cycle retire does not free a slot for allocation
        for (int k = 0; k < 8; k++) issue(64'h500 + 64'(4 * k), 64'h200 + 64'(k));
        decoded_instr_valid_i = 1'b1;
        decoded_instr_i       = '0;
        decoded_instr_i.pc    = 64'h600;
        wb_set(0, 3'd2, 64'h200, 1'b0, '0);
        wb_set(1, 3'd3, 64'h201, 1'b0, '0);
        #1;
        check("full_flag", 64'(full_o), 64'd1);
        check("full_ack", 64'(decoded_instr_ack_o), 64'd0);
        tick();
        wb_clear();
        begin
            exp_t e;
            e = exp_q.pop_front();
            commit_ack_i[0] = 1'b1;
            #1;
            check("full_retire_ack", 64'(decoded_instr_ack_o), 64'd0);
            check("full_retire_full", 64'(full_o), 64'd1);
            check("full_retire_result", commit_instr_o[0].result, e.result);
            tick();
            commit_ack_i = '0;
            #1;
            check("after_retire_full", 64'(full_o), 64'd0);
            check("after_retire_ack", 64'(decoded_instr_ack_o), 64'd1);
            check("after_retire_tid", 64'(issue_trans_id_o), 64'd2);
            e.pc = 64'h600;
            e.result = 64'h2F0;
            exp_q.push_back(e);
            tick();
            decoded_instr_valid_i = 1'b0;
            tb_tail = 3'd3;
            #1;
            check("refull", 64'(full_o), 64'd1);
        end

        // Drain to five entries, then flush with concurrent issue and writeback
        wb_set(0, 3'd4, 64'h202, 1'b0, '0);
        wb_set(1, 3'd5, 64'h203, 1'b0, '0);
        tick();
        wb_clear();
        retire(2);
        retire(1);
        flush_i               = 1'b1;
        decoded_instr_valid_i = 1'b1;
        wb_set(0, 3'd6, 64'h204, 1'b0, '0);
        #1;
        check("flush_ack", 64'(decoded_instr_ack_o), 64'd0);
        tick();
        flush_i               = 1'b0;
        decoded_instr_valid_i = 1'b0;
        wb_clear();
        check("flush_full", 64'(full_o), 64'd0);
        check("flush_c0_valid", 64'(commit_instr_o[0].valid), 64'd0);
        check("flush_c1_valid", 64'(commit_instr_o[1].valid), 64'd0);
        check("flush_tid", 64'(issue_trans_id_o), 64'd0);
        exp_q.delete();
        tb_tail = 3'd0;

        // Port collision: highest port wins; writeback to a free slot is dropped
        issue(64'h700, 64'h44);
        wb_set(1, 3'd0, 64'h43, 1'b0, '0);
        wb_set(3, 3'd0, 64'h44, 1'b0, '0);
        wb_set(2, 3'd1, 64'h99, 1'b0, '0);
        tick();
        wb_clear();
        retire(1);
        issue(64'h704, 64'h77);
        check("free_slot_wb_dropped", 64'(commit_instr_o[0].valid), 64'd0);

        // Asynchronous reset mid-fill
        issue(64'h708, 64'h78);
        wb_set(0, 3'd1, 64'h77, 1'b0, '0);
        tick();
        wb_clear();
        check("pre_rst_c0_valid", 64'(commit_instr_o[0].valid), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_c0_valid", 64'(commit_instr_o[0].valid), 64'd0);
        check("async_rst_tid", 64'(issue_trans_id_o), 64'd0);
        check("async_rst_full", 64'(full_o), 64'd0);
        #1 rst_ni = 1'b1;
        exp_q.delete();
        tb_tail = 3'd0;
        tick();
        issue(64'h800, 64'h88);
        wb_set(0, 3'd0, 64'h88, 1'b0, '0);
        tick();
        wb_clear();
        retire(1);
        check("end_empty_c0", 64'(commit_instr_o[0].valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_commit_queue.md
ROB_COMMIT_QUEUE -- requirements
Module: rob_commit_queue

Interface
REQ-001 Parameter NR_ENTRIES, default 8, queue depth; SHALL be a power of two equal to 2**TRANS_ID_BITS.
REQ-002 Parameter NR_COMMIT_PORTS, default 2, number of head entries presented to the commit stage.
REQ-003 Parameter NR_WB_PORTS, default 4, number of writeback ports.
REQ-004 clk_i  in  1  clock; one clock, all state on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  discard all entries (pipeline flush).
REQ-007 decoded_instr_i  in  scoreboard_entry_t  instruction to allocate.
REQ-008 decoded_instr_valid_i  in  1  allocation request.
REQ-009 decoded_instr_ack_o  out  1  allocation accepted this cycle.
REQ-010 issue_trans_id_o  out  TRANS_ID_BITS  slot index given to the accepted instruction (current tail).
REQ-011 trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  writeback slot index per port.
REQ-012 wbdata_i  in  NR_WB_PORTS x riscv::XLEN  writeback result per port.
REQ-013 ex_i  in  NR_WB_PORTS x exception_t  writeback exception per port.
REQ-014 wt_valid_i  in  NR_WB_PORTS  writeback valid per port.
REQ-015 commit_instr_o  out  NR_COMMIT_PORTS x scoreboard_entry_t  head entries, port 0 oldest.
REQ-016 commit_ack_i  in  NR_COMMIT_PORTS  commit stage retires the presented entry.
REQ-017 full_o  out  1  all NR_ENTRIES slots occupied.

Function
REQ-018 Per slot state: occupied bit, entry payload; payload .valid means result written back.
REQ-019 Pointers head, tail: TRANS_ID_BITS wide, wrap modulo NR_ENTRIES; count: TRANS_ID_BITS+1 wide, range 0..NR_ENTRIES.
REQ-020 decoded_instr_ack_o SHALL equal decoded_instr_valid_i AND NOT full_o AND NOT flush_i, using start-of-cycle count (no same-cycle free-by-commit bypass).
REQ-021 On accept: slot[tail] gets decoded_instr_i with .valid=0, occupied=1; tail+1 at next edge; issue_trans_id_o = tail combinationally.
REQ-022 Writeback port w with wt_valid_i[w] to an occupied slot SHALL set .valid=1, .result=wbdata_i[w]; .ex overwritten only when ex_i[w].valid=1.
REQ-023 Writeback to an unoccupied slot SHALL be ignored; two ports targeting one slot in one cycle: highest-numbered port wins.
REQ-024 commit_instr_o[i] = payload of slot[head+i] (mod NR_ENTRIES); .valid forced 0 unless slot occupied and written back; registered state only, no writeback bypass (written entry visible cycle after writeback).
REQ-025 Entries retired per cycle = number of asserted commit_ack_i bits; head advances by that count, retired slots cleared (occupied=0, .valid=0).
REQ-026 commit_ack_i[i] SHALL only be asserted with commit_ack_i[i-1] and commit_instr_o[i].valid; violation is an assertion failure.
REQ-027 Simultaneous accept and retire: count_next = count + accept - retired; full never blocks retire; empty never blocks accept.
REQ-028 flush_i SHALL clear all occupied/valid bits, head=tail=count=0 at next edge, override same-cycle accept, writeback and retire.
REQ-029 full_o = (count == NR_ENTRIES), registered-state derived.

Reset
REQ-030 While rst_ni=0: head=tail=count=0, all occupied and payload .valid bits 0; hence full_o=0, all commit_instr_o[i].valid=0, decoded_instr_ack_o=0 while valid_i low.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately, independent of clock.

Structure
REQ-032 scoreboard_entry_t, exception_t, TRANS_ID_BITS come from ariane_pkg; no new package types.
REQ-033 Single flat module, no sub-module; retire count via local popcount loop.

Verification
REQ-034 Issue 3 instr, writeback slots 0,1,2 with 0x11,0x22,0x33 -> next cycle commit_instr_o[0].result=0x11, [1]=0x22, both valid; ack 2'b11 -> head=2, [0].result=0x33.
REQ-035 Fill 8 entries, hold valid_i -> full_o=1, ack_o=0; same cycle ack 1 -> ack_o still 0; following cycle ack_o=1, count stays 8.
REQ-036 Writeback slot 1 only -> [0].valid=0, [1] not committable; then writeback slot 0 -> both valid next cycle.
REQ-037 head=6, issue 4 -> trans_ids 6,7,0,1; retire all -> head=2, count=0, no stale valid at wrapped slots.
REQ-038 Writeback with ex_i.valid=1 cause=2 to slot 0 -> commit_instr_o[0].ex.valid=1, cause=2; later non-ex writeback keeps ex.
REQ-039 flush_i with 5 entries plus concurrent issue and writeback -> next cycle count=0, all commit valids 0, ack_o=0 that cycle; async reset mid-fill likewise clears.
